// File: rtl/sensor_packet_spi_master.sv
// rtl/sensor_packet_spi_master.sv - SPI mode 0 master serialising one 16-byte sensor packet per request
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               request one packet (sampled only when idle)
//   roll, pitch, yaw    signed Euler fields, latched at acceptance
//   gyro_x/y/z          signed gyro fields, latched at acceptance
//   euler_valid         flags bit 0
//   gyro_valid          flags bit 1
//   cs_n, sck, sdo      registered SPI lines (CPOL=0, CPHA=0)
//   busy                high from acceptance through the end of the idle gap
//   done                one-cycle pulse on the cycle cs_n returns high
module sensor_packet_spi_master #(
    parameter int SCK_HALF = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int IDLE_GAP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] roll,
    input  logic [15:0] pitch,
    input  logic [15:0] yaw,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    input  logic        euler_valid,
    input  logic        gyro_valid,
    output logic        cs_n,
    output logic        sck,
    output logic        sdo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HALF_LAST  = 16'(SCK_HALF - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

    state_t       state;
    logic [15:0]  cnt;
    logic [6:0]   bit_cnt;
    logic [127:0] shreg;
    logic [127:0] packet;

    // Byte 0 lands in the top bits so the shifter always emits its MSB next.
    assign packet = {8'hAA, roll, pitch, yaw, gyro_x, gyro_y, gyro_z,
                     6'b0, gyro_valid, euler_valid, 16'h0000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cs_n    <= 1'b1;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= packet;
                        sdo     <= packet[127];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            // Falling edge: next bit goes out now so it is settled
                            // for a whole low phase before the receiver samples it.
                            sck <= 1'b0;
                            if (bit_cnt == 7'd127) begin
                                state <= S_HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                                sdo     <= shreg[126];
                                shreg   <= {shreg[126:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        cs_n    <= 1'b1;
                        done    <= 1'b1;
                        sdo     <= 1'b0;
                        bit_cnt <= '0;
                        // With no gap, busy drops together with cs_n.
                        if (IDLE_GAP == 0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_packet_spi_master.sv
// tb/tb_sensor_packet_spi_master.sv - scoreboard bench for sensor_packet_spi_master
module tb_sensor_packet_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] roll = '0, pitch = '0, yaw = '0;
    logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic        euler_valid = 1'b0, gyro_valid = 1'b0;
    logic        cs_n_a, sck_a, sdo_a, busy_a, done_a;
    logic        cs_n_b, sck_b, sdo_b, busy_b, done_b;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] E1 = 128'hAA12_34FE_DC00_0180_007F_FFA5_A501_0000;
    localparam logic [127:0] E3 = 128'hAA01_0203_0405_0607_0809_0A0B_0C03_0000;
    localparam logic [127:0] E4 = 128'hAADE_ADBE_EFCA_FE00_00FF_FF5A_5A02_0000;

    always #5 clk = ~clk;

    sensor_packet_spi_master #(.SCK_HALF(2), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .roll(roll), .pitch(pitch), .yaw(yaw),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .euler_valid(euler_valid), .gyro_valid(gyro_valid),
        .cs_n(cs_n_a), .sck(sck_a), .sdo(sdo_a), .busy(busy_a), .done(done_a)
    );

    sensor_packet_spi_master #(.SCK_HALF(1), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .roll(roll), .pitch(pitch), .yaw(yaw),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .euler_valid(euler_valid), .gyro_valid(gyro_valid),
        .cs_n(cs_n_b), .sck(sck_b), .sdo(sdo_b), .busy(busy_b), .done(done_b)
    );

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // cs_n low window: CS_SETUP + 256*SCK_HALF + CS_HOLD
    function automatic int lo_exp(input int ch);
        return (ch == 0) ? 516 : 260;
    endfunction

    function automatic int gap_exp(input int ch);
        return (ch == 0) ? 4 : 0;
    endfunction

    // ---------------- monitor ----------------
    logic [1:0] cs_v, sck_v, sdo_v, busy_v, done_v;
    assign cs_v   = {cs_n_b, cs_n_a};
    assign sck_v  = {sck_b, sck_a};
    assign sdo_v  = {sdo_b, sdo_a};
    assign busy_v = {busy_b, busy_a};
    assign done_v = {done_b, done_a};

    logic [127:0] m_sh[2];
    int           m_bits[2];
    int           m_lo[2];
    int           m_gap[2];
    logic [1:0]   m_in_gap = '0;
    logic [1:0]   p_cs = 2'b11, p_sck = '0, p_sdo = '0;

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                m_sh[ch] = '0;
                m_bits[ch] = 0;
                m_lo[ch] = 0;
                m_gap[ch] = 0;
                m_in_gap[ch] = 1'b0;
                p_cs[ch] = 1'b1;
                p_sck[ch] = 1'b0;
                p_sdo[ch] = 1'b0;
            end else begin
                if (cs_v[ch]) begin
                    check("sck_low_while_cs_high", 128'(sck_v[ch]), 128'(0));
                    check("sdo_low_while_cs_high", 128'(sdo_v[ch]), 128'(0));
                end
                if (sdo_v[ch] !== p_sdo[ch])
                    check("sdo_change_with_sck_low", 128'(sck_v[ch]), 128'(0));
                if (!cs_v[ch]) begin
                    m_lo[ch]++;
                    if (sck_v[ch] && !p_sck[ch]) begin
                        m_sh[ch] = {m_sh[ch][126:0], sdo_v[ch]};
                        m_bits[ch]++;
                    end
                end
                if (cs_v[ch] && !p_cs[ch]) begin
                    check("done_at_cs_rise", 128'(done_v[ch]), 128'(1));
                    check("sck_rise_count", 128'(m_bits[ch]), 128'(128));
                    check("cs_low_cycles", 128'(m_lo[ch]), 128'(lo_exp(ch)));
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL packet_unexpected: got %0h, expected no packet", m_sh[ch]);
                    end else begin
                        check("packet", m_sh[ch], exp_q.pop_front());
                    end
                    m_bits[ch] = 0;
                    m_lo[ch] = 0;
                    if (gap_exp(ch) == 0) begin
                        check("busy_low_at_cs_rise", 128'(busy_v[ch]), 128'(0));
                    end else begin
                        m_in_gap[ch] = 1'b1;
                        m_gap[ch] = 0;
                    end
                end else begin
                    check("no_done_elsewhere", 128'(done_v[ch]), 128'(0));
                end
                if (m_in_gap[ch]) begin
                    if (busy_v[ch]) begin
                        m_gap[ch]++;
                    end else begin
                        check("busy_gap_cycles", 128'(m_gap[ch]), 128'(gap_exp(ch)));
                        m_in_gap[ch] = 1'b0;
                    end
                end
                p_cs[ch] = cs_v[ch];
                p_sck[ch] = sck_v[ch];
                p_sdo[ch] = sdo_v[ch];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y,
                              input logic [15:0] gx, input logic [15:0] gy, input logic [15:0] gz,
                              input logic ev, input logic gv);
        roll = r; pitch = p; yaw = y;
        gyro_x = gx; gyro_y = gy; gyro_z = gz;
        euler_valid = ev; gyro_valid = gv;
    endtask

    task automatic pulse_start(input int ch);
        if (ch == 0) start_a = 1'b1;
        else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int ch, input string name);
        int n;
        n = 0;
        while (((ch == 0) ? busy_a : busy_b) && n < 3000) begin
            tick();
            n++;
        end
        n_vec++;
        if (n >= 3000) begin
            n_err++;
            $display("FAIL %s: busy still high after %0d cycles, expected idle", name, n);
        end
        repeat (3) tick();
    endtask

    initial begin
        int acc, hi, rises, n;
        logic pb, pc, ps;

        // reset state
        repeat (3) tick();
        check("reset_cs_n", 128'({cs_n_b, cs_n_a}), 128'(2'b11));
        check("reset_sck", 128'({sck_b, sck_a}), 128'(0));
        check("reset_sdo", 128'({sdo_b, sdo_a}), 128'(0));
        check("reset_busy", 128'({busy_b, busy_a}), 128'(0));
        check("reset_done", 128'({done_b, done_a}), 128'(0));
        reset = 1'b0;
        repeat (2) tick();

        // 1: basic packet
        set_fields(16'h1234, 16'hFEDC, 16'h0001, 16'h8000, 16'h7FFF, 16'hA5A5, 1'b1, 1'b0);
        exp_q.push_back(E1);
        pulse_start(0);
        wait_idle(0, "s1_idle");

        // 2: inputs changed and start re-pulsed while busy
        exp_q.push_back(E1);
        pulse_start(0);
        for (int c = 1; c <= 450; c++) begin
            tick();
            if (c == 1 || c == 100 || c == 400) begin
                set_fields(16'(c), 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 16'h3333, 1'b0, 1'b1);
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        wait_idle(0, "s2_idle");
        repeat (30) tick();
        check("s2_single_packet", 128'(exp_q.size()), 128'(0));

        // 3: start held high, back-to-back packets
        set_fields(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 1'b1, 1'b1);
        repeat (3) exp_q.push_back(E3);
        start_a = 1'b1;
        acc = 0; hi = 0; n = 0;
        pb = busy_a; pc = cs_n_a;
        while (acc < 3 && n < 3000) begin
            tick();
            n++;
            if (cs_n_a) hi++;
            if (!cs_n_a && pc) begin
                if (acc >= 1) check("s3_cs_high_between", 128'(hi), 128'(5));
                hi = 0;
            end
            if (busy_a && !pb) acc++;
            pb = busy_a;
            pc = cs_n_a;
        end
        start_a = 1'b0;
        check("s3_accept_count", 128'(acc), 128'(3));
        wait_idle(0, "s3_idle");

        // 4: reset in the middle of a packet
        set_fields(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 1'b1, 1'b1);
        pulse_start(0);
        rises = 0; n = 0; ps = sck_a;
        while (rises < 40 && n < 3000) begin
            tick();
            n++;
            if (sck_a && !ps) rises++;
            ps = sck_a;
        end
        check("s4_reached_40_rises", 128'(rises), 128'(40));
        reset = 1'b1;
        tick();
        check("s4_cs_n", 128'(cs_n_a), 128'(1));
        check("s4_sck", 128'(sck_a), 128'(0));
        check("s4_sdo", 128'(sdo_a), 128'(0));
        check("s4_busy", 128'(busy_a), 128'(0));
        check("s4_done", 128'(done_a), 128'(0));
        reset = 1'b0;
        repeat (3) tick();
        set_fields(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0000, 16'hFFFF, 16'h5A5A, 1'b0, 1'b1);
        exp_q.push_back(E4);
        pulse_start(0);
        wait_idle(0, "s4_idle");

        // 6: fast instance, no idle gap
        set_fields(16'h1234, 16'hFEDC, 16'h0001, 16'h8000, 16'h7FFF, 16'hA5A5, 1'b1, 1'b0);
        exp_q.push_back(E1);
        pulse_start(1);
        wait_idle(1, "s6_idle");

        repeat (10) tick();
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
